// File: rtl/serial_tx.sv
// serial_tx: memory-mapped 8N1 serial transmitter with a small byte FIFO.
// Stores to BASE queue a byte, stores to BASE+1 flush the queue and the
// overflow counter. Loads return status (BASE) or the overflow count (BASE+1)
// combinationally on the shared d_data bus.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module serial_tx #(
    parameter logic [31:0] BASE   = 32'h20,
    parameter int          CLKDIV = 16,
    parameter int          DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        strobe,
    input  logic        mem_rw,
    input  logic [31:0] d_addr,
    inout  wire  [31:0] d_data,
    output logic        txd,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKDIV);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKDIV - 1);

`ifdef SERIAL_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Bus decode
    logic hit_data;
    logic hit_ctrl;
    logic store_data;
    logic flush;
    logic load_hit;

    assign hit_data   = strobe && (d_addr == BASE);
    assign hit_ctrl   = strobe && (d_addr == (BASE + 32'd1));
    assign store_data = hit_data && mem_rw;
    assign flush      = hit_ctrl && mem_rw;
    assign load_hit   = (hit_data || hit_ctrl) && !mem_rw;

    // Only the low byte of store data is meaningful
    logic unused_store_bits;
    assign unused_store_bits = ^d_data[31:8];

    // FIFO state
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    ovf_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic          pop_ok;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    // Fullness is judged on the pre-pop count, so a same-cycle pop never rescues a byte
    assign push   = store_data && !full;
    assign drop   = store_data && full;
    // A flush in the same cycle wins over the shifter's pop
    assign pop_ok = !empty && !flush;

    // Shift engine state
    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          busy_q;

    // FIFO pointers, occupancy and overflow counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= d_data[7:0];
        end
    end

    // Shift engine state register; busy reflects the previous edge's result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= (state_q != S_IDLE) || !empty;
        end
    end

    // Shift engine next-state: bit timing, frame sequencing and FIFO pops
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_ok) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    timer_d = TIMER_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_RELOAD;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_PARITY: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_RELOAD;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    // Chain straight into the next frame when data is waiting
                    if (pop_ok) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        timer_d = TIMER_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level decoded from the registered engine state
    always_comb begin
        txd = 1'b1;
        case (state_q)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift_q[bit_q];
            S_PARITY: txd = ^shift_q;
            default:  txd = 1'b1;
        endcase
    end

    assign busy = busy_q;

    // Load data: status word or overflow counter
    logic [8:0]  count_ext;
    logic [7:0]  count_sat;
    logic [31:0] status_word;
    logic [31:0] rdata;

    // Status assembly with the count saturated to 8 bits
    always_comb begin
        count_ext              = '0;
        count_ext[CW-1:0]      = count_q;
        count_sat              = count_ext[8] ? 8'hFF : count_ext[7:0];
        status_word            = '0;
        status_word[7:0]       = count_sat;
        status_word[8]         = full;
        status_word[9]         = empty;
        status_word[10]        = (state_q != S_IDLE);
        status_word[11]        = PARITY_EN;
        rdata                  = hit_data ? status_word : {24'h0, ovf_q};
    end

    assign d_data = load_hit ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a queue-based model of the
// transmitter (byte queue plus a countdown of the frame in flight).
module tb_serial_tx;

    localparam int          CLKDIV = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h20;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int          FRAME    = (PAR ? 11 : 10) * CLKDIV;
    localparam logic [31:0] PARB     = PAR ? 32'h800 : 32'h0;
    // The bus is pulled high, so an undriven d_data reads all ones
    localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        strobe = 1'b0;
    logic        mem_rw = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] drv = '0;
    logic        oe = 1'b0;
    tri1  [31:0] d_data;
    wire         txd;
    wire         busy;

    assign d_data = oe ? drv : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    serial_tx #(.BASE(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (strobe),
        .mem_rw  (mem_rw),
        .d_addr  (d_addr),
        .d_data  (d_data),
        .txd     (txd),
        .busy    (busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model
    logic [7:0] q[$];
    int         sh_left = 0;
    logic [7:0] cur_byte = '0;
    int         ovf = 0;
    logic       busy_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = PARB;
        s[7:0]   = 8'(q.size());
        s[8]     = (q.size() == DEPTH);
        s[9]     = (q.size() == 0);
        s[10]    = (sh_left > 0);
        return s;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr);
        if (addr == BASE)        return model_status();
        if (addr == BASE + 32'd1) return 32'(ovf);
        return BUS_IDLE;
    endfunction

    // Expected line level from the position within the frame in flight
    function automatic logic model_txd();
        int pos;
        if (sh_left == 0) return 1'b1;
        pos = (FRAME - sh_left) / CLKDIV;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return cur_byte[pos-1];
        if (pos == 9 && PAR) return ^cur_byte;
        return 1'b1;
    endfunction

    // One clock edge of the model, using the state before the edge
    task automatic model_edge(input bit s, input bit rw, input logic [31:0] addr, input logic [31:0] data);
        bit flush_c, store_c, can_pop;
        int pre;
        flush_c  = s && rw && (addr == BASE + 32'd1);
        store_c  = s && rw && (addr == BASE);
        pre      = q.size();
        busy_exp = (sh_left > 0) || (pre > 0);
        can_pop  = (sh_left <= 1) && (pre > 0) && !flush_c;
        if (flush_c) begin
            q.delete();
            ovf = 0;
        end
        if (can_pop) cur_byte = q.pop_front();
        if (store_c) begin
            if (pre == DEPTH) begin
                if (ovf < 255) ovf++;
            end else begin
                q.push_back(data[7:0]);
            end
        end
        if (can_pop) sh_left = FRAME;
        else if (sh_left > 0) sh_left--;
    endtask

    // One bus cycle: drive, check any load data, clock, check line and busy
    task automatic bus(input bit s, input bit rw, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd);
        strobe = s;
        mem_rw = rw;
        d_addr = addr;
        drv    = data;
        oe     = s && rw;
        #1;
        rd = d_data;
        if (s && !rw) check("load", d_data, model_load(addr));
        else if (!oe) check("bus_idle", d_data, BUS_IDLE);
        @(posedge clk);
        model_edge(s, rw, addr, data);
        #1;
        strobe = 1'b0;
        mem_rw = 1'b0;
        oe     = 1'b0;
        d_addr = '0;
        check("txd", {31'b0, txd}, {31'b0, model_txd()});
        check("busy", {31'b0, busy}, {31'b0, busy_exp});
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        repeat (n) bus(1'b0, 1'b0, 32'h0, 32'h0, rd);
    endtask

    task automatic do_reset();
        strobe  = 1'b0;
        oe      = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        q.delete();
        sh_left  = 0;
        ovf      = 0;
        busy_exp = 1'b0;
        #1;
        reset_n = 1'b1;
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_bus", d_data, BUS_IDLE);
    endtask

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input int gap, input logic [31:0] exp);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.gap = gap; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic [10:0] seq;
        int          nbits;
        int          r;

        // Idle after reset, unmapped accesses, then the overflow scenario
        add(0, 32'h20, 0, 0, 32'h200 | PARB);
        add(0, 32'h21, 0, 0, 32'h0);
        add(0, 32'h22, 0, 0, BUS_IDLE);
        add(1, 32'h1F, 32'h55, 0, 0);
        add(0, 32'h1F, 0, 0, BUS_IDLE);
        add(0, 32'h20, 0, 0, 32'h200 | PARB);
        add(0, 32'h21, 0, 0, 32'h0);
        add(1, 32'h20, 32'h01, 7, 0);
        add(1, 32'h20, 32'h02, 7, 0);
        add(1, 32'h20, 32'h03, 7, 0);
        add(1, 32'h20, 32'h04, 7, 0);
        add(1, 32'h20, 32'h05, 7, 0);
        add(1, 32'h20, 32'h06, 0, 0);
        add(0, 32'h20, 0, 0, 32'h504 | PARB);
        add(0, 32'h21, 0, 0, 32'h1);
        add(0, 32'h22, 0, 0, BUS_IDLE);
        add(1, 32'h1F, 32'h77, 0, 0);
        add(0, 32'h21, 0, 240, 32'h1);
        add(0, 32'h20, 0, 0, 32'h200 | PARB);
        add(0, 32'h21, 0, 0, 32'h1);

        do_reset();

        foreach (tbl[i]) begin
            bus(1'b1, tbl[i].rw, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].rw) check($sformatf("vec%0d", i), rd, tbl[i].exp);
            idle(tbl[i].gap);
        end

        // Single frame of 0xA5: start, LSB-first data, optional parity, stop
        nbits = PAR ? 11 : 10;
        seq   = PAR ? {1'b1, 1'b0, 8'hA5, 1'b0} : {1'b0, 1'b1, 8'hA5, 1'b0};
        bus(1'b1, 1'b1, BASE, 32'hFFFF_FFA5, rd);
        idle(1);
        for (int i = 0; i < nbits * CLKDIV; i++) begin
            check($sformatf("frame_bit%0d", i / CLKDIV), {31'b0, txd}, {31'b0, seq[i / CLKDIV]});
            idle(1);
        end
        check("busy_tail", {31'b0, busy}, 32'h1);
        idle(1);
        check("busy_fall", {31'b0, busy}, 32'h0);

        // Flush mid-frame with a full FIFO and a nonzero overflow count
        for (int i = 0; i < 6; i++) bus(1'b1, 1'b1, BASE, 32'h11 + 32'(i), rd);
        idle(10);
        bus(1'b1, 1'b1, BASE + 32'd1, 32'h0, rd);
        bus(1'b1, 1'b0, BASE + 32'd1, 32'h0, rd);
        check("flush_ovf", rd, 32'h0);
        bus(1'b1, 1'b0, BASE, 32'h0, rd);
        check("flush_status", rd, 32'h600 | PARB);
        idle(FRAME + 5);
        bus(1'b1, 1'b0, BASE, 32'h0, rd);
        check("flush_done", rd, 32'h200 | PARB);

        // Reset while shifting data bits
        bus(1'b1, 1'b1, BASE, 32'h3C, rd);
        idle(15);
        do_reset();
        bus(1'b1, 1'b0, BASE, 32'h0, rd);
        check("rst_status", rd, 32'h200 | PARB);

        // Randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12)       bus(1'b1, 1'b1, BASE, $urandom, rd);
            else if (r < 14)  bus(1'b1, 1'b1, BASE + 32'd1, $urandom, rd);
            else if (r < 22)  bus(1'b1, 1'b0, BASE, 32'h0, rd);
            else if (r < 28)  bus(1'b1, 1'b0, BASE + 32'd1, 32'h0, rd);
            else if (r < 31)  bus(1'b1, 1'b0, (r[0] ? 32'h22 : 32'h1F), 32'h0, rd);
            else if (r < 33)  bus(1'b1, 1'b1, 32'h40 + 32'($urandom_range(0, 3)), $urandom, rd);
            else              bus(1'b0, 1'b0, 32'h0, 32'h0, rd);
        end
        idle(FRAME * (DEPTH + 2));
        bus(1'b1, 1'b0, BASE, 32'h0, rd);
        check("final_status", rd, 32'h200 | PARB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
